// File: rtl/motor_drive_sequencer.sv
// H-bridge sequencer: all-off dead-time on direction change, stepped duty soft-start,
// PWM gating of the bridge and a latched over-current shutdown.
//
// state | meaning
// IDLE  | bridge off, waiting for a valid direction request
// DEAD  | bridge off, dead-time running before the new direction is applied
// RAMP  | direction applied, duty stepping up towards the request
// RUN   | direction applied, duty tracking the request
// FAULT | over-current latched, bridge off until comparators are clear and stop is requested
module motor_drive_sequencer #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 1000,
    parameter int START_DUTY  = 64,
    parameter int RAMP_STEP   = 16,
    parameter int RAMP_DIV    = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          req_dir,
    input  logic [PWM_BITS-1:0] req_duty,
    input  logic                compA,
    input  logic                compB,
    output logic                JA1,
    output logic                JA2,
    output logic                JA3,
    output logic                JA4,
    output logic [3:0]          active_dir,
    output logic [PWM_BITS-1:0] duty_cur,
    output logic                fault,
    output logic [2:0]          state
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] START_V   = PWM_BITS'(START_DUTY);
    localparam logic [PWM_BITS:0]   STEP_V    = (PWM_BITS + 1)'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEAD  = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          tgt_q, tgt_d;
    logic [3:0]          act_q, act_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                fault_q, fault_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [RW-1:0]       ramp_q, ramp_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS:0]   ramp_sum;
    logic                req_move;
    logic                pwm_on;

    assign req_move = (req_dir == 4'b1001) || (req_dir == 4'b0110) ||
                      (req_dir == 4'b0101) || (req_dir == 4'b1010);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            act_q   <= '0;
            duty_q  <= '0;
            fault_q <= 1'b0;
            dead_q  <= '0;
            ramp_q  <= '0;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            act_q   <= act_d;
            duty_q  <= duty_d;
            fault_q <= fault_d;
            dead_q  <= dead_d;
            ramp_q  <= ramp_d;
            pwm_q   <= pwm_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        act_d    = act_q;
        duty_d   = duty_q;
        fault_d  = fault_q;
        dead_d   = dead_q;
        ramp_d   = ramp_q;
        // one extra bit so the step never wraps past full scale
        ramp_sum = {1'b0, duty_q} + STEP_V;
        if (!compA || !compB) begin
            state_d = S_FAULT;
            act_d   = '0;
            duty_d  = '0;
            fault_d = 1'b1;
        end else if (state_q == S_FAULT) begin
            if (!req_move) begin
                state_d = S_IDLE;
                fault_d = 1'b0;
            end
        end else if (!req_move) begin
            state_d = S_IDLE;
            act_d   = '0;
            duty_d  = '0;
        end else if (state_q == S_IDLE || req_dir != tgt_q) begin
            state_d = S_DEAD;
            tgt_d   = req_dir;
            act_d   = '0;
            duty_d  = '0;
            dead_d  = '0;
        end else begin
            case (state_q)
                S_DEAD: begin
                    if (dead_q == DEAD_LAST) begin
                        state_d = S_RAMP;
                        act_d   = tgt_q;
                        duty_d  = (START_V < req_duty) ? START_V : req_duty;
                        ramp_d  = '0;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                S_RAMP: begin
                    if (req_duty < duty_q) begin
                        duty_d = req_duty;
                    end else if (req_duty == duty_q) begin
                        state_d = S_RUN;
                    end else if (ramp_q == RAMP_LAST) begin
                        ramp_d = '0;
                        duty_d = (ramp_sum > {1'b0, req_duty}) ? req_duty : ramp_sum[PWM_BITS-1:0];
                    end else begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (req_duty < duty_q) begin
                        duty_d = req_duty;
                    end else if (req_duty > duty_q) begin
                        state_d = S_RAMP;
                        ramp_d  = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_on = (pwm_q < duty_q);
        JA1    = act_q[0] & pwm_on;
        JA2    = act_q[1] & pwm_on;
        JA3    = act_q[2] & pwm_on;
        JA4    = act_q[3] & pwm_on;
    end

    assign active_dir = act_q;
    assign duty_cur   = duty_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: directed scenarios plus a randomized run, every
// cycle compared against a countdown-style behavioural model of the sequencing rules.
module tb_motor_drive_sequencer;
    localparam int DEAD  = 4;
    localparam int DIV   = 4;
    localparam int STEP  = 64;
    localparam int START = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_dir;
    logic [7:0] req_duty;
    logic       compA, compB;
    logic       JA1, JA2, JA3, JA4;
    logic [3:0] active_dir;
    logic [7:0] duty_cur;
    logic       fault;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    int m_st, m_act, m_duty, m_fault, m_pwm, m_tgt, m_dead_left, m_ramp_left;
    int cnt1, cnt4;

    motor_drive_sequencer #(
        .PWM_BITS(8), .DEAD_CYCLES(DEAD), .START_DUTY(START),
        .RAMP_STEP(STEP), .RAMP_DIV(DIV)
    ) dut (
        .clock(clock), .reset(reset), .req_dir(req_dir), .req_duty(req_duty),
        .compA(compA), .compB(compB),
        .JA1(JA1), .JA2(JA2), .JA3(JA3), .JA4(JA4),
        .active_dir(active_dir), .duty_cur(duty_cur), .fault(fault), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic bit is_move(input int d);
        return d == 9 || d == 6 || d == 5 || d == 10;
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Model: dead-time and ramp kept as "edges remaining until the next event".
    task automatic model_step();
        int dir, rd;
        dir = int'(req_dir);
        rd  = int'(req_duty);
        if (!reset) begin
            m_st = 0; m_act = 0; m_duty = 0; m_fault = 0; m_pwm = 0;
            m_tgt = 0; m_dead_left = 0; m_ramp_left = 0;
            return;
        end
        m_pwm = (m_pwm + 1) % 256;
        if (!compA || !compB) begin
            m_st = 4; m_act = 0; m_duty = 0; m_fault = 1;
        end else if (m_st == 4) begin
            if (!is_move(dir)) begin m_st = 0; m_fault = 0; end
        end else if (!is_move(dir)) begin
            m_st = 0; m_act = 0; m_duty = 0;
        end else if (m_st == 0 || dir != m_tgt) begin
            m_st = 1; m_tgt = dir; m_act = 0; m_duty = 0; m_dead_left = DEAD;
        end else if (m_st == 1) begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_st = 2; m_act = m_tgt; m_duty = (START < rd) ? START : rd;
                m_ramp_left = DIV;
            end
        end else if (m_st == 2) begin
            if (rd < m_duty) m_duty = rd;
            else if (rd == m_duty) m_st = 3;
            else begin
                m_ramp_left--;
                if (m_ramp_left == 0) begin
                    m_duty = min3(m_duty + STEP, rd, 255);
                    m_ramp_left = DIV;
                end
            end
        end else begin
            if (rd < m_duty) m_duty = rd;
            else if (rd > m_duty) begin m_st = 2; m_ramp_left = DIV; end
        end
    endtask

    task automatic tick();
        int ja_exp;
        @(posedge clock);
        model_step();
        #1;
        ja_exp = (m_pwm < m_duty) ? m_act : 0;
        check("state", 32'(state), m_st);
        check("active_dir", 32'(active_dir), m_act);
        check("duty_cur", 32'(duty_cur), m_duty);
        check("fault", 32'(fault), m_fault);
        check("ja", 32'({JA4, JA3, JA2, JA1}), ja_exp);
        check("shoot_through", 32'(JA1 & JA2), 0);
    endtask

    function automatic logic [3:0] pick_dir();
        case ($urandom_range(0, 5))
            0: return 4'b0000;
            1: return 4'b1001;
            2: return 4'b0110;
            3: return 4'b0101;
            4: return 4'b1010;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        reset = 1'b0; req_dir = 4'b0000; req_duty = 8'd0; compA = 1'b1; compB = 1'b1;
        m_st = 0; m_act = 0; m_duty = 0; m_fault = 0; m_pwm = 0;
        m_tgt = 0; m_dead_left = 0; m_ramp_left = 0;

        // reset and idle
        tick(); tick();
        reset = 1'b1;
        tick();
        check("idle_state", 32'(state), 0);
        check("idle_duty", 32'(duty_cur), 0);

        // start forward at full duty
        req_dir = 4'b1001; req_duty = 8'd255;
        repeat (DEAD) begin
            tick();
            check("dead_off", 32'(active_dir), 0);
        end
        tick();
        check("start_dir", 32'(active_dir), 4'b1001);
        check("start_duty", 32'(duty_cur), 64);
        repeat (DIV) tick();
        check("ramp_128", 32'(duty_cur), 128);
        repeat (DIV) tick();
        check("ramp_192", 32'(duty_cur), 192);
        repeat (DIV) tick();
        check("ramp_255", 32'(duty_cur), 255);
        tick();
        check("run_state", 32'(state), 3);

        cnt1 = 0; cnt4 = 0;
        repeat (256) begin
            tick();
            cnt1 += int'(JA1);
            cnt4 += int'(JA4);
        end
        check("pwm_ja1_on", cnt1, 255);
        check("pwm_ja4_on", cnt4, 255);

        // reversal
        req_dir = 4'b0110;
        repeat (DEAD) begin
            tick();
            check("rev_off", 32'({JA4, JA3, JA2, JA1}), 0);
        end
        tick();
        check("rev_dir", 32'(active_dir), 4'b0110);
        check("rev_duty", 32'(duty_cur), 64);
        repeat (16) tick();

        // fault latch
        compA = 1'b0;
        tick();
        check("fault_set", 32'(fault), 1);
        check("fault_state", 32'(state), 4);
        check("fault_ja", 32'({JA4, JA3, JA2, JA1}), 0);
        compA = 1'b1; req_dir = 4'b1001;
        repeat (5) tick();
        check("fault_hold", 32'(state), 4);
        req_dir = 4'b0000;
        tick();
        check("fault_clear_state", 32'(state), 0);
        check("fault_clear", 32'(fault), 0);

        // duty drop then invalid code
        req_dir = 4'b1001; req_duty = 8'd255;
        repeat (20) tick();
        check("pre_drop_duty", 32'(duty_cur), 255);
        req_duty = 8'd32;
        tick();
        check("drop_duty", 32'(duty_cur), 32);
        req_dir = 4'b1111;
        tick();
        check("invalid_state", 32'(state), 0);
        check("invalid_ja", 32'({JA4, JA3, JA2, JA1}), 0);

        // direction change in the middle of dead-time
        req_dir = 4'b1001; req_duty = 8'd200;
        repeat (3) tick();
        req_dir = 4'b0101;
        repeat (DEAD) begin
            tick();
            check("middead_off", 32'(active_dir), 0);
        end
        tick();
        check("middead_dir", 32'(active_dir), 4'b0101);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) req_dir = pick_dir();
            if ($urandom_range(0, 29) == 0) req_duty = 8'($urandom_range(0, 255));
            compA = ($urandom_range(0, 299) != 0);
            compB = ($urandom_range(0, 299) != 0);
            reset = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Sequencing controller that sits between the line-following direction logic and the H-bridge pins JA1..JA4. It takes a requested 4-bit direction code and an 8-bit duty request and drives the bridge safely:
- inserts an all-off dead-time on every direction change (shoot-through protection);
- soft-starts the duty with a stepped ramp;
- gates the bridge with PWM;
- latches an over-current fault from the comparators until the requester commands stop.

## Interface
Parameters:
- PWM_BITS, 8, width of duty and PWM counter; PWM period = 2^PWM_BITS cycles
- DEAD_CYCLES, 1000, all-off cycles inserted before any new direction is applied (≥1)
- START_DUTY, 64, initial duty on leaving dead-time
- RAMP_STEP, 16, duty increment per ramp tick
- RAMP_DIV, 4096, clock cycles per ramp tick (≥1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_dir  in  4  requested code: stop 0000, forward 1001, backward 0110, right 0101, left 1010; any other value is treated as stop
- req_duty  in  PWM_BITS  requested duty
- compA, compB  in  1  current comparators, 0 = over-current
- JA1, JA2, JA3, JA4  out  1  bridge controls = active_dir[0..3] AND pwm_on
- active_dir  out  4  direction currently applied
- duty_cur  out  PWM_BITS  duty currently applied
- fault  out  1  latched over-current flag
- state  out  3  IDLE=0, DEAD=1, RAMP=2, RUN=3, FAULT=4

## Operation
- **Reset** (reset==0 at an edge):
  - state=IDLE; active_dir=0000; duty_cur=0; fault=0.
  - PWM, dead and ramp counters = 0; target register = 0000.
  - All JA = 0.
- **PWM:**
  - pwm_cnt is free-running, 0 → 2^PWM_BITS−1, then wraps to 0.
  - pwm_on = (pwm_cnt < duty_cur). Duty 0 gives always-off; duty 255 gives 255/256 on.
- **Evaluation priority each edge:** reset > fault > stop/invalid > direction change > ramp/run.
- **Fault:**
  - compA==0 or compB==0 in any state → FAULT; active_dir=0000, duty_cur=0, fault=1.
  - FAULT → IDLE only when compA & compB == 1 and req_dir decodes as stop on the same edge; fault clears to 0 on that edge.
- **Stop/invalid request** in DEAD, RAMP or RUN → IDLE; active_dir=0000, duty_cur=0.
- **IDLE:**
  - valid non-stop req_dir and no fault → DEAD.
  - Latch target=req_dir; dead_cnt=0.
- **DEAD:**
  - active_dir=0000; dead_cnt increments each cycle.
  - When dead_cnt==DEAD_CYCLES−1: active_dir←target, duty_cur←min(START_DUTY, req_duty), ramp_cnt←0, → RAMP.
- **Direction change:** in RAMP, RUN or DEAD, a valid non-stop req_dir ≠ target → DEAD.
  - Re-latch target; active_dir=0000; duty_cur=0; dead_cnt=0.
  - The dead-time restarts from zero.
- **RAMP:**
  - ramp_cnt counts 0..RAMP_DIV−1. At terminal count: duty_cur ← min(duty_cur+RAMP_STEP, req_duty, 2^PWM_BITS−1).
  - Compute the sum at PWM_BITS+1 width; no wrap.
  - If req_duty < duty_cur at any edge, duty_cur←req_duty immediately.
  - When duty_cur==req_duty → RUN.
- **RUN:**
  - req_duty < duty_cur → duty_cur←req_duty, stay in RUN.
  - req_duty > duty_cur → RAMP with ramp_cnt=0.
- **Duty 0 request** while moving: stays in RUN with duty 0; the direction is held but all JA are 0.

## Timing
- All state is registered. JA is a combinational AND of the registered active_dir, duty_cur and pwm_cnt only; there is no input-to-output combinational path.
- Fault latency: comparator low sampled at edge k → JA all 0 immediately after edge k.
- Dead-time: the request sampled at edge k forces JA=0000 after edge k. active_dir takes the new code after edge k+DEAD_CYCLES, giving exactly DEAD_CYCLES all-off cycles.
- Ramp: each increment takes effect exactly RAMP_DIV cycles after the previous one (or after RAMP entry).
- Reset mid-operation: the state is reached at the reset edge; JA=0 right after it.

## Test plan
Bench parameters: DEAD_CYCLES=4, RAMP_DIV=4, RAMP_STEP=64, START_DUTY=64, PWM_BITS=8.
- **Reset/idle:** reset=0 for 2 cycles, then reset=1 with req_dir=0000 → state=0, all JA=0, fault=0, duty_cur=0.
- **Start and ramp:** req_dir=1001, req_duty=255.
  - JA=0000 for 4 cycles, then active_dir=1001.
  - duty_cur sequence 64, 128, 192, 255, 4 cycles apart, then state=RUN.
  - JA1/JA4 high for 255 of every 256 cycles.
- **Reversal:** while in RUN, req_dir→0110 → JA=0000 on the next cycle for 4 cycles, then active_dir=0110 with duty_cur=64. At no point is JA1 high at the same time as JA2.
- **Fault latch:** in RUN, pulse compA=0 for 1 cycle → fault=1, state=4, JA=0 the next cycle.
  - State stays 4 while req_dir=1001 is held.
  - req_dir=0000 → IDLE, fault=0.
- **Duty drop and invalid code:** in RUN at 255, req_duty=32 → duty_cur=32 on the next edge. Then req_dir=1111 → IDLE, JA=0.
- **Mid-dead change:** during DEAD for 1001, after 2 cycles switch req_dir to 0101 → the dead count restarts; active_dir=0101 appears 4 cycles after the switch.
